// File: rtl/cpu_mem_responder.sv
// Shared word-addressed RAM serving CPU fetch and data requests one at a time
// with a fixed accept-to-response latency; data requests win arbitration.
module cpu_mem_responder #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic                 i_valid,
  output logic [WORD_SIZE-1:0] i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic                 d_valid,
  output logic [WORD_SIZE-1:0] d_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  sel_data_q, sel_data_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  commit;
  logic                  ram_we;

  logic [WORD_SIZE-1:0]  mem [0:(1<<ADDR_WIDTH)-1];
  logic                  i_valid_q, d_valid_q;
  logic [WORD_SIZE-1:0]  i_data_q, d_rdata_q;

  // Address bits above the RAM index alias onto the same words.
  generate
    if (ADDR_WIDTH < WORD_SIZE) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^{i_addr[WORD_SIZE-1:ADDR_WIDTH], d_addr[WORD_SIZE-1:ADDR_WIDTH]};
    end
  endgenerate

  assign i_ready = (state_q == IDLE) && reset_n;
  assign d_ready = (state_q == IDLE) && reset_n;
  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_data_d = sel_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          sel_data_d = 1'b1;
          we_d       = d_we;
          addr_d     = d_addr[ADDR_WIDTH-1:0];
          wdata_d    = d_wdata;
          cnt_d      = CNT_INIT;
          state_d    = BUSY;
        end else if (i_req) begin
          sel_data_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = i_addr[ADDR_WIDTH-1:0];
          cnt_d      = CNT_INIT;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_data_q <= sel_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      i_valid_q <= commit && !sel_data_q;
      d_valid_q <= commit && sel_data_q;
      if (commit && !sel_data_q)
        i_data_q <= mem[addr_q];
      if (commit && sel_data_q)
        d_rdata_q <= we_q ? wdata_q : mem[addr_q];
    end
  end

  // Gated by reset_n so a write caught by reset never reaches the array.
  assign ram_we = commit && sel_data_q && we_q && reset_n;

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vector table, fetch-stream sequence and
// randomized traffic on a LATENCY=2 and a LATENCY=3 instance against a transaction model.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, i_req, i_ready, i_valid, d_req, d_we, d_ready, d_valid;
  logic [1:0][15:0] i_addr, i_data, d_addr, d_wdata, d_rdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cpu_mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(gi == 0 ? 2 : 3)) u_dut (
      .clk(clk), .reset_n(rst_n[gi]),
      .i_req(i_req[gi]), .i_addr(i_addr[gi]), .i_ready(i_ready[gi]),
      .i_valid(i_valid[gi]), .i_data(i_data[gi]),
      .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
      .d_ready(d_ready[gi]), .d_valid(d_valid[gi]), .d_rdata(d_rdata[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lat(input int n);
    return (n == 0) ? 2 : 3;
  endfunction

  // Transaction model: a request accepted at edge k completes at edge k+LATENCY.
  bit [1:0]    m_init, m_busy, m_acc_i, m_acc_d, m_iv, m_dv, m_id_k, m_dd_k, m_port_d, m_we;
  int unsigned m_due [2];
  int          m_addr [2];
  logic [15:0] m_wd [2];
  logic [15:0] m_id [2];
  logic [15:0] m_dd [2];
  logic [15:0] m_mem [2][256];
  bit          m_known [2][256];

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      m_acc_i[n] = 1'b0;
      m_acc_d[n] = 1'b0;
      if (!rst_n[n]) begin
        m_init[n] = 1'b1; m_busy[n] = 1'b0; m_iv[n] = 1'b0; m_dv[n] = 1'b0;
        m_id[n] = 16'h0; m_dd[n] = 16'h0; m_id_k[n] = 1'b1; m_dd_k[n] = 1'b1;
      end else begin
        m_iv[n] = 1'b0;
        m_dv[n] = 1'b0;
        if (m_busy[n]) begin
          if (cyc == m_due[n]) begin
            m_busy[n] = 1'b0;
            if (m_port_d[n] && m_we[n]) begin
              m_mem[n][m_addr[n]] = m_wd[n];
              m_known[n][m_addr[n]] = 1'b1;
              m_dd[n] = m_wd[n]; m_dd_k[n] = 1'b1; m_dv[n] = 1'b1;
            end else if (m_port_d[n]) begin
              m_dd[n] = m_mem[n][m_addr[n]]; m_dd_k[n] = m_known[n][m_addr[n]]; m_dv[n] = 1'b1;
            end else begin
              m_id[n] = m_mem[n][m_addr[n]]; m_id_k[n] = m_known[n][m_addr[n]]; m_iv[n] = 1'b1;
            end
          end
        end else if (d_req[n]) begin
          m_busy[n] = 1'b1; m_due[n] = cyc + lat(n); m_port_d[n] = 1'b1;
          m_we[n] = d_we[n]; m_addr[n] = int'(d_addr[n]) % 256; m_wd[n] = d_wdata[n];
          m_acc_d[n] = 1'b1;
        end else if (i_req[n]) begin
          m_busy[n] = 1'b1; m_due[n] = cyc + lat(n); m_port_d[n] = 1'b0;
          m_we[n] = 1'b0; m_addr[n] = int'(i_addr[n]) % 256;
          m_acc_i[n] = 1'b1;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (m_init[n]) begin
        chk_b($sformatf("u%0d_i_ready", n), i_ready[n], !m_busy[n] && rst_n[n]);
        chk_b($sformatf("u%0d_d_ready", n), d_ready[n], !m_busy[n] && rst_n[n]);
        chk_b($sformatf("u%0d_i_valid", n), i_valid[n], m_iv[n]);
        chk_b($sformatf("u%0d_d_valid", n), d_valid[n], m_dv[n]);
        chk_b($sformatf("u%0d_valid_overlap", n), i_valid[n] & d_valid[n], 1'b0);
        if (m_id_k[n]) chk_w($sformatf("u%0d_i_data", n), i_data[n], m_id[n]);
        if (m_dd_k[n]) chk_w($sformatf("u%0d_d_rdata", n), d_rdata[n], m_dd[n]);
        if (m_iv[n] || m_dv[n])
          $display("u%0d cycle %0d: %s response data=%h", n, cyc, m_iv[n] ? "fetch" : "data",
                   m_iv[n] ? i_data[n] : d_rdata[n]);
      end
    end
  end

  typedef struct {
    bit          rst, ireq, dreq, dwe, e_rdy, e_iv, e_dv;
    logic [15:0] iaddr, daddr, dwd, e_id, e_dd;
  } vec_t;
  vec_t tbl[$];

  // Row: inputs held over one edge, then the outputs expected in the following cycle.
  task automatic add(input int rst, ireq, iaddr, dreq, dwe, daddr, dwd,
                     input int e_rdy, e_iv, e_id, e_dv, e_dd);
    vec_t v;
    v.rst = 1'(rst); v.ireq = 1'(ireq); v.iaddr = 16'(iaddr);
    v.dreq = 1'(dreq); v.dwe = 1'(dwe); v.daddr = 16'(daddr); v.dwd = 16'(dwd);
    v.e_rdy = 1'(e_rdy); v.e_iv = 1'(e_iv); v.e_id = 16'(e_id);
    v.e_dv = 1'(e_dv); v.e_dd = 16'(e_dd);
    tbl.push_back(v);
  endtask

  task automatic d_access(input int n, input bit we, input logic [15:0] a, input logic [15:0] wd);
    bit got;
    got = 1'b0;
    d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = a; d_wdata[n] = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      if (m_acc_d[n]) got = 1'b1;
    end
    d_req[n] = 1'b0;
    chk_b("d_accept_seen", got, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (d_valid[n]) got = 1'b1;
    end
    #1;
    chk_b("d_response_seen", got, 1'b1);
  endtask

  function automatic logic [15:0] rand_addr();
    return 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
  endfunction

  logic [15:0] exp_f [3] = '{16'h000A, 16'h000B, 16'h000C};

  initial begin
    int nv, fidx;
    int unsigned last;
    rst_n = 2'b00; i_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    //   rst ireq iaddr dreq dwe daddr dwd       rdy iv id       dv dd
    add(0, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 0);
    add(0, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       0, 0);
    add(1, 0, 0,      1, 1, 5,      'h1234,     0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       1, 'h1234);
    add(1, 1, 5,      0, 0, 0,      0,          0, 0, 0,       0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          1, 1, 'h1234,  0, 'h1234);
    add(1, 1, 5,      1, 0, 5,      0,          0, 0, 'h1234,  0, 'h1234);
    add(1, 1, 5,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'h1234);
    add(1, 1, 5,      0, 0, 0,      0,          1, 0, 'h1234,  1, 'h1234);
    add(1, 1, 5,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          1, 1, 'h1234,  0, 'h1234);
    add(1, 0, 0,      1, 1, 'h0105, 'hA5A5,     0, 0, 'h1234,  0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'h1234);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 'h1234,  1, 'hA5A5);
    add(1, 0, 0,      1, 0, 'h0005, 0,          0, 0, 'h1234,  0, 'hA5A5);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'hA5A5);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 'h1234,  1, 'hA5A5);
    add(1, 0, 0,      1, 1, 3,      'h1111,     0, 0, 'h1234,  0, 'hA5A5);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 'h1234,  0, 'hA5A5);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 'h1234,  1, 'h1111);
    add(1, 0, 0,      1, 1, 3,      'hBEEF,     0, 0, 'h1234,  0, 'h1111);
    add(0, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       0, 0);
    add(1, 0, 0,      1, 0, 3,      0,          0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       1, 'h1111);
    add(1, 0, 0,      0, 0, 0,      0,          1, 0, 0,       0, 'h1111);

    @(negedge clk); #1;
    foreach (tbl[r]) begin
      rst_n[0] = tbl[r].rst; i_req[0] = tbl[r].ireq; i_addr[0] = tbl[r].iaddr;
      d_req[0] = tbl[r].dreq; d_we[0] = tbl[r].dwe;
      d_addr[0] = tbl[r].daddr; d_wdata[0] = tbl[r].dwd;
      @(negedge clk);
      chk_b($sformatf("vec%0d_i_ready", r), i_ready[0], tbl[r].e_rdy);
      chk_b($sformatf("vec%0d_d_ready", r), d_ready[0], tbl[r].e_rdy);
      chk_b($sformatf("vec%0d_i_valid", r), i_valid[0], tbl[r].e_iv);
      chk_w($sformatf("vec%0d_i_data", r), i_data[0], tbl[r].e_id);
      chk_b($sformatf("vec%0d_d_valid", r), d_valid[0], tbl[r].e_dv);
      chk_w($sformatf("vec%0d_d_rdata", r), d_rdata[0], tbl[r].e_dd);
      $display("vec %0d: rdy=%b iv=%b id=%h dv=%b dd=%h", r, i_ready[0], i_valid[0],
               i_data[0], d_valid[0], d_rdata[0]);
      #1;
    end

    // Fetch stream on the LATENCY=3 instance: accept->valid takes 3 edges and the
    // next accept lands on the valid cycle, so pulses are 4 edges apart.
    rst_n[1] = 1'b1;
    d_access(1, 1'b1, 16'h0000, 16'h000A);
    d_access(1, 1'b1, 16'h0001, 16'h000B);
    d_access(1, 1'b1, 16'h0002, 16'h000C);
    nv = 0; fidx = 0; last = 0;
    i_req[1] = 1'b1; i_addr[1] = 16'h0000;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (i_valid[1]) begin
        if (nv < 3) chk_w($sformatf("fetch%0d_data", nv), i_data[1], exp_f[nv]);
        if (nv > 0) chk_w("fetch_spacing", 16'(cyc - last), 16'd4);
        last = cyc;
        nv++;
      end
      #1;
      if (m_acc_i[1]) begin
        fidx++;
        if (fidx < 3) i_addr[1] = 16'(fidx);
        else i_req[1] = 1'b0;
      end
    end
    chk_w("fetch_count", 16'(nv), 16'd3);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (m_acc_d[n]) d_req[n] = 1'b0;
        if (m_acc_i[n]) i_req[n] = 1'b0;
        rst_n[n] = ($urandom_range(0, 99) != 0);
        if (!d_req[n] && $urandom_range(0, 3) == 0) begin
          d_req[n] = 1'b1; d_we[n] = 1'($urandom_range(0, 1));
          d_addr[n] = rand_addr(); d_wdata[n] = 16'($urandom);
        end
        if (!i_req[n] && $urandom_range(0, 2) == 0) begin
          i_req[n] = 1'b1; i_addr[n] = rand_addr();
        end
      end
    end

    @(negedge clk); #1;
    rst_n = 2'b11; i_req = 2'b00; d_req = 2'b00;
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
